// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter onto one req/gnt/rvalid memory bus.
// Outstanding transactions are tracked in an in-order owner FIFO so responses route back.
module mem_port_arbiter #(
   parameter int MAX_OUTSTANDING = 2,
   parameter int STARVE_LIMIT    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_req_i,
   input  logic [31:0] instr_addr_i,
   output logic        instr_gnt_o,
   output logic        instr_rvalid_o,
   output logic [31:0] instr_rdata_o,
   output logic        instr_err_o,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   output logic        mem_we_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_gnt_i,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   input  logic        mem_err_i,
   output logic        orphan_rsp_o
);

   localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [MAX_OUTSTANDING-1:0] owner_q;
   logic [PW-1:0]              wr_ptr;
   logic [PW-1:0]              rd_ptr;
   logic [CW-1:0]              count;
   logic [SW-1:0]              starve_cnt;

   logic full;
   logic empty;
   logic sel_instr;
   logic push;
   logic pop;
   logic head_is_data;

   assign full      = (count == CW'(MAX_OUTSTANDING));
   assign empty     = (count == '0);
   assign sel_instr = instr_req_i && (!data_req_i || (starve_cnt == SW'(STARVE_LIMIT)));

   // Grants are blocked outright when full, even if a pop frees a slot this cycle.
   assign mem_req_o   = !rst && !full && (instr_req_i || data_req_i);
   assign instr_gnt_o = mem_req_o && mem_gnt_i && sel_instr;
   assign data_gnt_o  = mem_req_o && mem_gnt_i && !sel_instr;

   always_comb begin
      mem_addr_o  = '0;
      mem_we_o    = 1'b0;
      mem_be_o    = '0;
      mem_wdata_o = '0;
      if (mem_req_o) begin
         if (sel_instr) begin
            mem_addr_o = instr_addr_i;
            mem_be_o   = 4'hF;
         end else begin
            mem_addr_o  = data_addr_i;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_wdata_o = data_wdata_i;
         end
      end
   end

   assign push         = mem_req_o && mem_gnt_i;
   assign pop          = !rst && mem_rvalid_i && !empty;
   assign head_is_data = owner_q[rd_ptr];

   assign instr_rvalid_o = pop && !head_is_data;
   assign data_rvalid_o  = pop && head_is_data;
   assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
   assign instr_err_o    = instr_rvalid_o && mem_err_i;
   assign data_rdata_o   = data_rvalid_o ? mem_rdata_i : '0;
   assign data_err_o     = data_rvalid_o && mem_err_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         owner_q <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
      end else begin
         if (push) begin
            owner_q[wr_ptr] <= !sel_instr;
            wr_ptr <= (wr_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr + PW'(1);
         end
         if (pop)
            rd_ptr <= (rd_ptr == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr + PW'(1);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

   // Starvation counter holds while full so a blocked bus does not count as lost arbitration.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         starve_cnt <= '0;
      else if (!instr_req_i || instr_gnt_o)
         starve_cnt <= '0;
      else if (!full && (starve_cnt != SW'(STARVE_LIMIT)))
         starve_cnt <= starve_cnt + SW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         orphan_rsp_o <= 1'b0;
      else if (mem_rvalid_i && empty)
         orphan_rsp_o <= 1'b1;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single core memory bus between the instruction-fetch port and the load/store data port.
- Uses the req/gnt/rvalid protocol on every port.
- Arbitrates request phases and tracks outstanding transactions in an in-order owner FIFO.
- Routes each response (rdata/err/rvalid) back to the requester that issued it. Sits between the fetch/LSU stages and the memory interconnect.

Parameters:
- MAX_OUTSTANDING, 2: maximum granted-but-unanswered transactions; depth of owner FIFO (≥1).
- STARVE_LIMIT, 4: consecutive cycles instr may lose arbitration before it gets priority (≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_req_i  in  1  fetch request.
- instr_addr_i  in  32  fetch address.
- instr_gnt_o  out  1  fetch request accepted.
- instr_rvalid_o  out  1  fetch response valid.
- instr_rdata_o  out  32  fetch response data.
- instr_err_o  out  1  fetch response error.
- data_req_i  in  1  load/store request.
- data_addr_i  in  32  load/store address.
- data_we_i  in  1  1 = store.
- data_be_i  in  4  byte enables.
- data_wdata_i  in  32  store data.
- data_gnt_o  out  1  load/store accepted.
- data_rvalid_o  out  1  load/store response valid.
- data_rdata_o  out  32  load data.
- data_err_o  out  1  load/store error.
- mem_req_o  out  1  downstream request.
- mem_addr_o  out  32  downstream address.
- mem_we_o  out  1  downstream write enable.
- mem_be_o  out  4  downstream byte enables.
- mem_wdata_o  out  32  downstream write data.
- mem_gnt_i  in  1  downstream grant.
- mem_rvalid_i  in  1  downstream response valid.
- mem_rdata_i  in  32  downstream response data.
- mem_err_i  in  1  downstream response error.
- orphan_rsp_o  out  1  sticky: rvalid received with empty owner FIFO.

Behaviour:
- Reset: FIFO empty, count 0, starve counter 0, orphan_rsp_o 0. All gnt/rvalid outputs and mem_req_o are 0 while rst is high.
- Request phase is combinational; there is no added latency.
- Selection:
  - Data port wins by default.
  - Instr wins when starve_cnt == STARVE_LIMIT, or when only instr requests.
- Blocking: full = (count == MAX_OUTSTANDING). If full, mem_req_o = 0 and both gnt outputs are 0, even if a response pops in the same cycle.
- Driving the bus: when not full and either requester is active, mem_req_o = 1 and the mem_addr/we/be/wdata of the selected port are driven.
  - For instr: we = 0, be = 4'hF, wdata = 0.
  - When idle, mem_addr/we/be/wdata are all 0.
- Grants: selected port's gnt = mem_gnt_i & mem_req_o; the other port's gnt = 0.
- Push: each handshake (mem_req_o & mem_gnt_i) pushes the owner bit (0 = instr, 1 = data) at the FIFO tail.
- Pop: mem_rvalid_i pops the head. rdata/err go to the owner's *_rdata_o/*_err_o in the same cycle, and the owner's rvalid is asserted for that one cycle.
  - The non-owner's rvalid is 0, and its rdata/err are 0.
- Ordering: responses are in order; the memory never responds in the grant cycle (minimum one cycle later).
- Simultaneous push and pop: count is unchanged and the pointers advance; the wrap-around is modulo MAX_OUTSTANDING.
- Orphan response: mem_rvalid_i while the FIFO is empty does not pop and drives no port rvalid. orphan_rsp_o sets and holds until rst.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) each cycle instr_req_i = 1 and instr_gnt_o = 0.
  - Clears on an instr grant, or whenever instr_req_i = 0.
  - Does not increment while the block is full.
- Requesters hold req/addr/wdata stable until gnt; the arbiter may switch selection while a request is ungranted (no lock).
- Reset mid-operation: all outstanding state is discarded. Responses to pre-reset requests arriving after reset are orphans.

Test Plan:
- Instr-only: instr_req_i = 1 at addr 0x100, mem_gnt_i = 1, response 0x00000013 two cycles later -> instr_gnt_o for 1 cycle; instr_rvalid_o = 1 with rdata 0x00000013; data_rvalid_o = 0.
- Contention (STARVE_LIMIT = 4): both requesting every cycle, mem_gnt_i = 1 always, responses never return (MAX_OUTSTANDING set large) -> data granted cycles 0–3, instr granted cycle 4, starve counter returns to 0.
- Interleaved order: grant data (store 0xDEADBEEF, be = 4'b0011), then instr; responses R1, R2 -> R1 appears on data_rvalid_o, R2 on instr_rvalid_o; mem_we_o = 1 and mem_be_o = 4'b0011 on the first handshake.
- Full FIFO (MAX_OUTSTANDING = 2): two grants with no response -> mem_req_o = 0 with both gnts 0. In the cycle rvalid arrives, the grant is still blocked; the next cycle grants. Count and pointers wrap correctly over 10 transactions.
- Orphan response: mem_rvalid_i = 1 with empty FIFO -> no port rvalid; orphan_rsp_o = 1 and stays 1 until rst.
- Reset mid-flight: one outstanding, assert rst -> all outputs 0; the late rvalid after release raises orphan_rsp_o.
